// File: rtl/jk_bank_seq_pkg.sv
// Shared opcodes, FSM encoding and helpers for the JK bank sequencer.
// Build with JK_BANK_SEQ_VERIFY_EN to enable post-step readback checking.
package jk_bank_seq_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_UP     = 3'd4;
    localparam logic [2:0] OP_DOWN   = 3'd5;
    localparam logic [2:0] OP_TOGGLE = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_step(input logic [2:0] op);
        return (op == OP_UP) || (op == OP_DOWN) || (op == OP_TOGGLE);
    endfunction

endpackage

// File: rtl/jk_bank_seq_excite.sv
// JK excitation: set bits that must rise, reset bits that must fall,
// hold everything else.
module jk_excite #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    assign j = ~q & nxt;
    assign k = q & ~nxt;

endmodule

// File: rtl/jk_ff.sv
// Single JK flip-flop of the external bank.
// Async active-low reset clears Q.
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_seq.sv
// Command sequencer driving J/K of an external jk_ff bank, one step per DRIVE/APPLY pair.
// Define JK_BANK_SEQ_VERIFY_EN to check Q after each step and abort on error.
module jk_bank_seq
    import jk_bank_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             busy,
    output logic             done,
    output logic             bad_op,
    output logic             mismatch
);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] steps_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_ex;
    logic [WIDTH-1:0] k_ex;
    logic             accept;
    logic             short_cmd;
    logic             miss;

    assign accept    = cmd_valid & cmd_ready;
    assign cnt_inc   = cnt + 1'b1;
    assign short_cmd = (cmd_op == OP_NOP) || (cmd_op == OP_RSVD)
                     || (is_step(cmd_op) && (cmd_steps == '0));

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign bad_op    = done && (op_r == OP_RSVD);

    always_comb begin
        nxt = q_i;
        unique case (1'b1)
            (op_r == OP_CLEAR):  nxt = '0;
            (op_r == OP_SET):    nxt = '1;
            (op_r == OP_LOAD):   nxt = data_r;
            (op_r == OP_UP):     nxt = q_i + 1'b1;
            (op_r == OP_DOWN):   nxt = q_i - 1'b1;
            (op_r == OP_TOGGLE): nxt = ~q_i;
            default:             nxt = q_i;
        endcase
    end

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .q   (q_i),
        .nxt (nxt),
        .j   (j_ex),
        .k   (k_ex)
    );

`ifdef JK_BANK_SEQ_VERIFY_EN
    logic [WIDTH-1:0] exp_r;
    logic             chk_r;
    logic             mis_r;

    // chk_r marks the cycle right after APPLY, when Q must equal exp_r
    assign miss     = chk_r && (q_i != exp_r);
    assign mismatch = mis_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_r <= '0;
            chk_r <= 1'b0;
            mis_r <= 1'b0;
        end else begin
            chk_r <= (state == ST_APPLY);
            if (state == ST_DRIVE) begin
                exp_r <= nxt;
            end
            if (miss) begin
                mis_r <= 1'b1;
            end
        end
    end
`else
    assign miss     = 1'b0;
    assign mismatch = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = short_cmd ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_nxt = miss ? ST_DONE : ST_APPLY;
            end
            ST_APPLY: begin
                if (!is_step(op_r) || (cnt_inc == steps_r)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            op_r    <= OP_NOP;
            data_r  <= '0;
            steps_r <= '0;
            cnt     <= '0;
            j_o     <= '0;
            k_o     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_r    <= cmd_op;
                data_r  <= cmd_data;
                steps_r <= cmd_steps;
                cnt     <= '0;
            end
            if ((state == ST_DRIVE) && !miss) begin
                j_o <= (op_r == OP_TOGGLE) ? '1 : j_ex;
                k_o <= (op_r == OP_TOGGLE) ? '1 : k_ex;
            end
            if (state == ST_APPLY) begin
                j_o <= '0;
                k_o <= '0;
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_jk_bank_seq.sv
// Directed bench: jk_bank_seq driving a 4-bit jk_ff bank, checked
// cycle by cycle against a timeline model plus literal pins.
module tb_jk_bank_seq;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       bad;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] q;
    } rec_t;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_steps;
    logic [WIDTH-1:0] q_bank;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] stuck;
    logic [WIDTH-1:0] j_o;
    logic [WIDTH-1:0] k_o;
    logic             busy;
    logic             done;
    logic             bad_op;
    logic             mismatch;

    int   n_chk;
    int   n_pass;
    int   cyc;
    int   acc_cyc;
    int   done_cyc;
    int   bad_cnt;
    bit   chk_en;
    logic [3:0] model_q;
    rec_t exp_q[$];

    assign q_in = q_bank & ~stuck;

    jk_bank_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .q_i       (q_in),
        .j_o       (j_o),
        .k_o       (k_o),
        .busy      (busy),
        .done      (done),
        .bad_op    (bad_op),
        .mismatch  (mismatch)
    );

    for (genvar g = 0; g < WIDTH; g++) begin : g_bank
        jk_ff u_ff (
            .clk (clk),
            .rst (rst),
            .j   (j_o[g]),
            .k   (k_o[g]),
            .q   (q_bank[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [3:0] f_next(input logic [2:0] op,
                                          input logic [3:0] q,
                                          input logic [3:0] d);
        case (op)
            3'd1:    return 4'h0;
            3'd2:    return 4'hF;
            3'd3:    return d;
            3'd4:    return q + 4'd1;
            3'd5:    return q - 4'd1;
            3'd6:    return ~q;
            default: return q;
        endcase
    endfunction

    function automatic rec_t mk(input logic b, input logic dn, input logic bd,
                                input logic [3:0] j, input logic [3:0] k,
                                input logic [3:0] q);
        rec_t r;
        r.busy = b;
        r.done = dn;
        r.bad  = bd;
        r.j    = j;
        r.k    = k;
        r.q    = q;
        return r;
    endfunction

    // Expected per-cycle timeline, starting with the accept (IDLE) cycle
    task automatic plan(input logic [2:0] op, input logic [3:0] d,
                        input logic [7:0] s);
        logic [3:0] cur;
        logic [3:0] nx;
        logic [3:0] jj;
        logic [3:0] kk;
        bit         stp;
        int         n;
        cur = model_q;
        stp = (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, cur));
        if (op == 3'd0 || op == 3'd7 || (stp && s == 8'd0)) begin
            exp_q.push_back(mk(1'b1, 1'b1, op == 3'd7, 4'h0, 4'h0, cur));
        end else begin
            n = stp ? int'(s) : 1;
            for (int i = 0; i < n; i++) begin
                nx = f_next(op, cur, d);
                jj = (op == 3'd6) ? 4'hF : (~cur & nx);
                kk = (op == 3'd6) ? 4'hF : (cur & ~nx);
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, cur));
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, jj, kk, cur));
                cur = nx;
            end
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, cur));
        end
        model_q = cur;
    endtask

    always @(negedge clk) begin
        rec_t r;
        logic [16:0] act;
        logic [16:0] req;
        cyc++;
        if (done) done_cyc = cyc;
        if (bad_op) bad_cnt++;
        if (chk_en) begin
            if (exp_q.size() != 0) r = exp_q.pop_front();
            else r = mk(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, model_q);
            act = {busy, cmd_ready, done, bad_op, mismatch, j_o, k_o, q_in};
            req = {r.busy, ~r.busy, r.done, r.bad, 1'b0, r.j, r.k, r.q};
            check($sformatf("cycle%0d", cyc), 32'(act), 32'(req));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [3:0] d,
                       input logic [7:0] s, input bit wt = 1'b1);
        @(posedge clk);
        #2;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_steps = s;
        if (chk_en) plan(op, d, s);
        @(posedge clk);
        acc_cyc = cyc;
        #2;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        cmd_steps = '0;
        if (wt) wait_idle();
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        cyc       = 0;
        acc_cyc   = 0;
        done_cyc  = 0;
        bad_cnt   = 0;
        chk_en    = 1'b0;
        model_q   = 4'h0;
        stuck     = '0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        cmd_steps = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_j", 32'(j_o), 32'h0);
        check("rst_k", 32'(k_o), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_done", 32'(done), 32'h0);
        check("rst_mis", 32'(mismatch), 32'h0);
        @(posedge clk);
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;

        run(3'd3, 4'b1010, 8'd0);
        check("load_q", 32'(q_in), 32'ha);
        check("load_lat", 32'(done_cyc - acc_cyc), 32'd3);

        run(3'd3, 4'hE, 8'd0);
        run(3'd4, 4'h0, 8'd3);
        check("up_q", 32'(q_in), 32'h1);
        check("up_lat", 32'(done_cyc - acc_cyc), 32'd7);

        run(3'd1, 4'h0, 8'd0);
        check("clr_q", 32'(q_in), 32'h0);
        run(3'd5, 4'h0, 8'd2);
        check("dn_q", 32'(q_in), 32'he);
        check("dn_lat", 32'(done_cyc - acc_cyc), 32'd5);

        run(3'd3, 4'b0101, 8'd0);
        run(3'd6, 4'h0, 8'd1);
        check("tg_q", 32'(q_in), 32'ha);
        check("tg_lat", 32'(done_cyc - acc_cyc), 32'd3);

        bad_cnt = 0;
        run(3'd7, 4'h3, 8'd5);
        check("bad_lat", 32'(done_cyc - acc_cyc), 32'd1);
        check("bad_cnt", 32'(bad_cnt), 32'd1);
        check("bad_q", 32'(q_in), 32'ha);
        run(3'd4, 4'h0, 8'd0);
        check("up0_lat", 32'(done_cyc - acc_cyc), 32'd1);
        check("up0_bad", 32'(bad_cnt), 32'd1);
        check("up0_q", 32'(q_in), 32'ha);
        run(3'd0, 4'h0, 8'd0);
        check("nop_lat", 32'(done_cyc - acc_cyc), 32'd1);
        run(3'd2, 4'h0, 8'd0);
        check("set_q", 32'(q_in), 32'hf);

        run(3'd3, 4'd5, 8'd0);
        check("pre_rst_q", 32'(q_in), 32'h5);
        done_cyc = 0;
        run(3'd4, 4'h0, 8'd5, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst    = 1'b0;
        exp_q.delete();
        #1;
        check("mid_j", 32'(j_o), 32'h0);
        check("mid_k", 32'(k_o), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_done", 32'(done), 32'h0);
        check("mid_q", 32'(q_in), 32'h0);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        model_q = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_nodone", 32'(done_cyc), 32'd0);
        check("mid_idle", 32'(cmd_ready), 32'h1);
        chk_en = 1'b1;
        run(3'd4, 4'h0, 8'd1);
        check("post_rst_q", 32'(q_in), 32'h1);

`ifdef JK_BANK_SEQ_VERIFY_EN
        run(3'd1, 4'h0, 8'd0);
        chk_en   = 1'b0;
        stuck    = 4'b0001;
        done_cyc = 0;
        run(3'd4, 4'h0, 8'd3, 1'b0);
        for (int i = 0; i < 20 && done_cyc == 0; i++) @(posedge clk);
        check("v_lat", 32'(done_cyc - acc_cyc), 32'd4);
        check("v_mis", 32'(mismatch), 32'h1);
        repeat (5) @(posedge clk);
        #1;
        check("v_sticky", 32'(mismatch), 32'h1);
        stuck = '0;
        rst   = 1'b0;
        #1;
        check("v_clr", 32'(mismatch), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
